// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 responder backed by a 64-bit wide on-chip memory.
// Supports FIXED/INCR/WRAP bursts, byte-strobed writes and narrow transfers.
// Read and write channels are independent, each holding one transaction.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*        write address / data / response channels
//   S_AXI_AR*/R*           read address / data channels
//   LOCK/CACHE/PROT/QOS/REGION/USER inputs are accepted and ignored;
//   BUSER/RUSER are tied to 0.
module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  // write address
  input  logic [3:0]  S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWLOCK,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic [3:0]  S_AXI_AWQOS,
  input  logic [3:0]  S_AXI_AWREGION,
  input  logic [0:0]  S_AXI_AWUSER,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  // write data
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic [0:0]  S_AXI_WUSER,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  // write response
  output logic [3:0]  S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic [0:0]  S_AXI_BUSER,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  // read address
  input  logic [3:0]  S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARLOCK,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic [3:0]  S_AXI_ARQOS,
  input  logic [3:0]  S_AXI_ARREGION,
  input  logic [0:0]  S_AXI_ARUSER,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  // read data
  output logic [3:0]  S_AXI_RID,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic [0:0]  S_AXI_RUSER,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Offset compare also rejects addresses below BASE_ADDR (they wrap high).
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 3);
  endfunction

  // Address of the following beat; WRAP with an illegal length behaves as INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] res;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    if (burst == BURST_FIXED) begin
      res = addr;
    end else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (addr & ~mask) | ((addr + step) & mask);
    end else begin
      res = addr + step;
    end
    return res;
  endfunction

  // Backing store; not touched by reset.
  logic [63:0] mem [DEPTH];

  // Write channel state
  logic [1:0]  w_state_q, w_state_d;
  logic [3:0]  awid_q, awid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [1:0]  bresp_q, bresp_d;

  // Read channel state
  logic [0:0]  r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs_c, w_hs_c, ar_hs_c, r_hs_c, rlast_c;
  logic        w_inr_c;
  logic [63:0] wmask_c;
  logic [31:0] rd_addr_c;
  logic [63:0] rd_word_c;

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !rst;
  assign S_AXI_WREADY  = (w_state_q == W_DATA) && !rst;
  assign S_AXI_BVALID  = (w_state_q == W_RESP) && !rst;
  assign S_AXI_BID     = awid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BUSER   = 1'b0;

  assign rlast_c       = (rcnt_q == rlen_q);
  assign S_AXI_ARREADY = (r_state_q == R_IDLE) && !rst;
  assign S_AXI_RVALID  = (r_state_q == R_DATA) && !rst;
  assign S_AXI_RLAST   = (r_state_q == R_DATA) && rlast_c && !rst;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RUSER   = 1'b0;

  assign aw_hs_c = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs_c  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs_c = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs_c  = S_AXI_RVALID && S_AXI_RREADY;
  assign w_inr_c = in_range(waddr_q);

  // Byte strobes expanded to a bit mask for the read-modify-write.
  assign wmask_c = {{8{S_AXI_WSTRB[7]}}, {8{S_AXI_WSTRB[6]}}, {8{S_AXI_WSTRB[5]}},
                    {8{S_AXI_WSTRB[4]}}, {8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                    {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};

  // Read port address: the AR address when idle, else the next beat's address.
  always_comb begin
    rd_addr_c = S_AXI_ARADDR;
    if (r_state_q == R_DATA) begin
      rd_addr_c = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    end
  end

  assign rd_word_c = in_range(rd_addr_c) ? mem[word_idx(rd_addr_c)] : 64'd0;

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          awid_d    = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR;
          wlen_d    = S_AXI_AWLEN;
          wsize_d   = S_AXI_AWSIZE;
          wburst_d  = S_AXI_AWBURST;
          wcnt_d    = 8'd0;
          bresp_d   = (S_AXI_AWSIZE > 3'd3) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs_c) begin
          // Response codes are ordered so OR-merging gives DECERR priority.
          bresp_d = bresp_q
                  | (w_inr_c ? RESP_OKAY : RESP_DECERR)
                  | ((S_AXI_WLAST != (wcnt_q == wlen_q)) ? RESP_SLVERR : RESP_OKAY);
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rid_d     = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR;
          rlen_d    = S_AXI_ARLEN;
          rsize_d   = S_AXI_ARSIZE;
          rburst_d  = S_AXI_ARBURST;
          rcnt_d    = 8'd0;
          rdata_d   = rd_word_c;
          rresp_d   = ((S_AXI_ARSIZE > 3'd3) ? RESP_SLVERR : RESP_OKAY)
                    | (in_range(rd_addr_c) ? RESP_OKAY : RESP_DECERR);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs_c) begin
          if (rlast_c) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = rd_addr_c;
            rdata_d = rd_word_c;
            rresp_d = rresp_q | (in_range(rd_addr_c) ? RESP_OKAY : RESP_DECERR);
            rcnt_d  = rcnt_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awid_q    <= 4'd0;
      waddr_q   <= 32'd0;
      wlen_q    <= 8'd0;
      wsize_q   <= 3'd0;
      wburst_q  <= 2'd0;
      wcnt_q    <= 8'd0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rid_q     <= 4'd0;
      raddr_q   <= 32'd0;
      rlen_q    <= 8'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= 2'd0;
      rcnt_q    <= 8'd0;
      rdata_q   <= 64'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Strobed write; a same-edge read still latches the pre-write word.
  always_ff @(posedge clk) begin
    if (w_hs_c && w_inr_c) begin
      mem[word_idx(waddr_q)] <= (mem[word_idx(waddr_q)] & ~wmask_c)
                              | (S_AXI_WDATA & wmask_c);
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                       S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER,
                       S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                       S_AXI_ARREGION, S_AXI_ARUSER};

endmodule
